max7219_scroller: RTL

MAX7219_SCROLLER -- requirements
Module: max7219_scroller

---
 rtl/max7219_scroller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/max7219_scroller.sv
// -----------------------------------------------------------------------------
// max7219_scroller
//
// Column FIFO feeding a scrolling 8x8 frame. Columns arrive over a valid/ack
// handshake and queue in a DEPTH-entry FIFO. A free-running step counter fires
// once every STEP_CYCLES clocks; on each step the oldest queued column is
// shifted into the low byte of the frame and the oldest frame column falls off
// the top. With an empty FIFO the frame either scrolls in a blank column
// (FILL_BLANK=1) or holds still (FILL_BLANK=0).
//
// Parameters
//   STEP_CYCLES  clocks per scroll step (2..2^24)
//   DEPTH        FIFO depth, power of two (2..256)
//   FILL_BLANK   1 = scroll in 8'h00 when empty at a step, 0 = hold the frame
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high
//   in_column  one display column, bit n = row n
//   in_valid   in_column is valid
//   in_ack     FIFO can accept a column this cycle (registered count only)
//   out_frame  [7:0] newest column ... [63:56] oldest column
//   out_step   one-cycle pulse while a freshly shifted frame is presented
//   out_empty  FIFO holds zero columns
// -----------------------------------------------------------------------------
module max7219_scroller #(
    parameter int STEP_CYCLES = 1000000,
    parameter int DEPTH       = 16,
    parameter int FILL_BLANK  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_column,
    input  logic        in_valid,
    output logic        in_ack,
    output logic [63:0] out_frame,
    output logic        out_step,
    output logic        out_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STEP_CYCLES);

    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] step_cnt;

    logic       step_hit;
    logic       push;
    logic       pop;
    logic       shift;
    logic [7:0] shift_col;

    // in_ack depends only on the registered count (and reset), never on
    // in_valid, so upstream logic can form in_valid from in_ack freely.
    // Gating with reset keeps the handshake closed while reset is held.
    assign in_ack    = ~reset & (count < COUNT_MAX);
    assign out_empty = (count == '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        step_hit  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        shift     = 1'b0;
        shift_col = 8'h00;

        step_hit = (step_cnt == STEP_LAST);
        push     = in_valid & in_ack;
        // Pop decision uses the count at the start of the cycle, so a column
        // pushed into an empty FIFO during a step cycle waits for the next step.
        pop      = step_hit & (count != '0);
        shift    = pop | (step_hit & (FILL_BLANK != 0));
        if (pop) begin
            shift_col = mem[rd_ptr];
        end
    end

    // Free-running step cadence, independent of FIFO traffic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (step_hit) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + SW'(1);
        end
    end

    // NOTE: the storage array carries no reset; emptiness is defined by the
    // pointers and count, so clearing them discards the contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_column;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame shift register and step pulse; out_step marks the cycle in which
    // the newly shifted frame is first visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_frame <= 64'h0;
            out_step  <= 1'b0;
        end else begin
            out_step <= shift;
            if (shift) begin
                out_frame <= {out_frame[55:0], shift_col};
            end
        end
    end

endmodule
